// File: rtl/avaliador_de_comandos_if.sv
// Command-evaluator link: pattern-manager handshake, player input and score outputs.
// slave = the evaluator itself, master = its environment (pattern manager, input logic, display).
interface avaliador_de_comandos_if;
  logic        iniciar;
  logic [3:0]  prox_comando;
  logic        fim_de_jogo;
  logic        jogada_valida;
  logic [3:0]  jogada;
  logic        trocar_comando;
  logic [15:0] pontuacao;
  logic [7:0]  acertos;
  logic [7:0]  erros;
  logic [7:0]  sequencia;
  logic        resultado_valido;
  logic        resultado_acerto;
  logic        jogando;

  modport slave (
    input  iniciar, prox_comando, fim_de_jogo, jogada_valida, jogada,
    output trocar_comando, pontuacao, acertos, erros, sequencia,
           resultado_valido, resultado_acerto, jogando
  );

  modport master (
    output iniciar, prox_comando, fim_de_jogo, jogada_valida, jogada,
    input  trocar_comando, pontuacao, acertos, erros, sequencia,
           resultado_valido, resultado_acerto, jogando
  );
endinterface

// File: rtl/avaliador_de_comandos.sv
// Grades player input against each command from the pattern manager and keeps score.
// Optional COMBO_BONUS_EN: hit value scales x1..x4 with the streak (every 4 hits).
module avaliador_de_comandos #(
  parameter int unsigned JANELA_CICLOS = 50_000_000,
  parameter int unsigned ESPERA_CICLOS = 2,
  parameter int unsigned PONTOS_ACERTO = 10
) (
  input logic                    clk,
  input logic                    rst,
  avaliador_de_comandos_if.slave bus
);

  localparam int unsigned JW = $clog2(JANELA_CICLOS);
  localparam int unsigned EW = (ESPERA_CICLOS > 1) ? $clog2(ESPERA_CICLOS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PEDIR,
    ASSENTAR,
    JANELA,
    AVALIAR,
    FIM
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [EW-1:0] espera_q, espera_d;
  logic [JW-1:0] janela_q, janela_d;
  logic [3:0]  esperado_q, esperado_d;
  logic        acerto_pend_q, acerto_pend_d;
  logic        trocar_q, trocar_d;
  logic [15:0] pont_q, pont_d;
  logic [7:0]  acertos_q, acertos_d;
  logic [7:0]  erros_q, erros_d;
  logic [7:0]  seq_q, seq_d;
  logic        res_valido_q, res_valido_d;
  logic        res_acerto_q, res_acerto_d;
  logic        jogando_q, jogando_d;

  logic [9:0]  pontos;
  logic [16:0] soma;

  always_comb begin
`ifdef COMBO_BONUS_EN
    logic [1:0] mult;
    mult   = (seq_q[7:2] >= 6'd3) ? 2'd3 : seq_q[3:2];
    pontos = 10'(PONTOS_ACERTO) * (10'(mult) + 10'd1);
`else
    pontos = 10'(PONTOS_ACERTO);
`endif
  end

  // Score sum is one bit wider so overflow can be clamped instead of wrapping.
  assign soma = {1'b0, pont_q} + 17'(pontos);

  always_comb begin
    estado_d      = estado_q;
    espera_d      = espera_q;
    janela_d      = janela_q;
    esperado_d    = esperado_q;
    acerto_pend_d = acerto_pend_q;
    pont_d        = pont_q;
    acertos_d     = acertos_q;
    erros_d       = erros_q;
    seq_d         = seq_q;
    res_acerto_d  = res_acerto_q;
    res_valido_d  = 1'b0;

    unique case (estado_q)
      IDLE, FIM: begin
        if (bus.iniciar) begin
          pont_d       = '0;
          acertos_d    = '0;
          erros_d      = '0;
          seq_d        = '0;
          res_acerto_d = 1'b0;
          estado_d     = PEDIR;
        end
      end
      PEDIR: begin
        espera_d = '0;
        estado_d = ASSENTAR;
      end
      ASSENTAR: begin
        if (espera_q == EW'(ESPERA_CICLOS - 1)) begin
          if (bus.fim_de_jogo) begin
            estado_d = FIM;
          end else begin
            esperado_d = bus.prox_comando;
            janela_d   = '0;
            estado_d   = JANELA;
          end
        end else begin
          espera_d = espera_q + 1'b1;
        end
      end
      JANELA: begin
        janela_d = janela_q + 1'b1;
        // A press on the last window cycle still wins over the timeout.
        if (bus.jogada_valida) begin
          acerto_pend_d = (esperado_q != '0) && (bus.jogada == esperado_q);
          estado_d      = AVALIAR;
        end else if (janela_q == JW'(JANELA_CICLOS - 1)) begin
          acerto_pend_d = (esperado_q == '0);
          estado_d      = AVALIAR;
        end
      end
      AVALIAR: begin
        res_valido_d = 1'b1;
        res_acerto_d = acerto_pend_q;
        if (acerto_pend_q) begin
          acertos_d = (acertos_q == '1) ? acertos_q : acertos_q + 8'd1;
          seq_d     = (seq_q == '1) ? seq_q : seq_q + 8'd1;
          pont_d    = soma[16] ? '1 : soma[15:0];
        end else begin
          erros_d = (erros_q == '1) ? erros_q : erros_q + 8'd1;
          seq_d   = '0;
        end
        estado_d = PEDIR;
      end
      default: estado_d = IDLE;
    endcase

    // Strobes are registered off the state being entered so they align with it.
    trocar_d  = (estado_d == PEDIR);
    jogando_d = (estado_d != IDLE) && (estado_d != FIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q      <= IDLE;
      espera_q      <= '0;
      janela_q      <= '0;
      esperado_q    <= '0;
      acerto_pend_q <= 1'b0;
      trocar_q      <= 1'b0;
      pont_q        <= '0;
      acertos_q     <= '0;
      erros_q       <= '0;
      seq_q         <= '0;
      res_valido_q  <= 1'b0;
      res_acerto_q  <= 1'b0;
      jogando_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      espera_q      <= espera_d;
      janela_q      <= janela_d;
      esperado_q    <= esperado_d;
      acerto_pend_q <= acerto_pend_d;
      trocar_q      <= trocar_d;
      pont_q        <= pont_d;
      acertos_q     <= acertos_d;
      erros_q       <= erros_d;
      seq_q         <= seq_d;
      res_valido_q  <= res_valido_d;
      res_acerto_q  <= res_acerto_d;
      jogando_q     <= jogando_d;
    end
  end

  assign bus.trocar_comando   = trocar_q;
  assign bus.pontuacao        = pont_q;
  assign bus.acertos          = acertos_q;
  assign bus.erros            = erros_q;
  assign bus.sequencia        = seq_q;
  assign bus.resultado_valido = res_valido_q;
  assign bus.resultado_acerto = res_acerto_q;
  assign bus.jogando          = jogando_q;

endmodule

// File: tb/tb_avaliador_de_comandos.sv
// Scoreboard bench for avaliador_de_comandos with a behavioural pattern manager and score model.
module tb_avaliador_de_comandos;
  localparam int J   = 8;
  localparam int ESP = 2;
  localparam int PTS = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avaliador_de_comandos_if ifc ();

  avaliador_de_comandos #(
    .JANELA_CICLOS(J),
    .ESPERA_CICLOS(ESP),
    .PONTOS_ACERTO(PTS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct {
    bit acerto;
    int pont;
    int ac;
    int er;
    int seq;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int grades = 0;
  int m_pont, m_ac, m_er, m_seq;
  int pm_list[8192];
  int pm_n = 0;
  int pm_base = 0;
  int pm_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Pattern manager: each advance strobe presents the next list entry, then end-of-list.
  always @(posedge clk) begin
    if (rst) begin
      ifc.prox_comando <= '0;
      ifc.fim_de_jogo  <= 1'b0;
    end else if (ifc.trocar_comando) begin
      if (pm_cnt - pm_base < pm_n) begin
        ifc.prox_comando <= 4'(pm_list[pm_cnt - pm_base]);
        ifc.fim_de_jogo  <= 1'b0;
      end else begin
        ifc.fim_de_jogo <= 1'b1;
      end
      pm_cnt <= pm_cnt + 1;
    end
  end

  // Reference scoring: apply one grade to the model and queue the expected result.
  task automatic grade(input bit hit, input int expc);
    exp_t e;
    int pts;
    if (hit) begin
`ifdef COMBO_BONUS_EN
      pts = PTS * (1 + ((m_seq / 4 > 3) ? 3 : m_seq / 4));
`else
      pts = PTS;
`endif
      m_pont = (m_pont + pts > 65535) ? 65535 : m_pont + pts;
      m_ac   = (m_ac < 255) ? m_ac + 1 : 255;
      m_seq  = (m_seq < 255) ? m_seq + 1 : 255;
    end else begin
      m_er  = (m_er < 255) ? m_er + 1 : 255;
      m_seq = 0;
    end
    e.acerto = hit; e.pont = m_pont; e.ac = m_ac; e.er = m_er; e.seq = m_seq; e.cyc = expc;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.resultado_valido) begin
        grades++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grade: got a grade pulse expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("grade_cycle", cyc, e.cyc);
          chk("resultado_acerto", int'(ifc.resultado_acerto), int'(e.acerto));
          chk("pontuacao", int'(ifc.pontuacao), e.pont);
          chk("acertos", int'(ifc.acertos), e.ac);
          chk("erros", int'(ifc.erros), e.er);
          chk("sequencia", int'(ifc.sequencia), e.seq);
          chk("trocar_with_grade", int'(ifc.trocar_comando), 1);
        end
      end
    end
  end

  task automatic wait_trocar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ifc.trocar_comando) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL trocar_wait: got no advance strobe expected one within 64 cycles (cycle %0d)", cyc);
    end
  endtask

  // One command: window opens ESP+1 cycles after the strobe; optional press at window cycle k.
  task automatic do_cmd(input int esp, input bit press, input int k, input int code,
                        input bit noise, input bit dbl, input bit ini);
    bit ok;
    int p, w, adv;
    wait_trocar(ok);
    if (!ok) return;
    p = cyc;
    w = p + 1 + ESP;
    @(negedge clk);
    chk("trocar_width", int'(ifc.trocar_comando), 0);
    if (noise) begin
      ifc.jogada_valida = 1'b1;
      ifc.jogada = 4'($urandom_range(0, 15));
      @(negedge clk);
      ifc.jogada_valida = 1'b0;
    end else begin
      @(negedge clk);
    end
    if (!press) grade(esp == 0, w + J + 1);
    repeat (ESP - 1) @(negedge clk);
    chk("jogando_window", int'(ifc.jogando), 1);
    adv = 0;
    if (ini && (!press || k > 0)) begin
      ifc.iniciar = 1'b1;
      @(negedge clk);
      ifc.iniciar = 1'b0;
      adv = 1;
    end
    if (press) begin
      repeat (k - adv) @(negedge clk);
      ifc.jogada_valida = 1'b1;
      ifc.jogada = 4'(code);
      grade(esp != 0 && code == esp, w + k + 2);
      @(negedge clk);
      if (dbl) begin
        ifc.jogada = 4'(code ^ 1);
        @(negedge clk);
      end
      ifc.jogada_valida = 1'b0;
    end
  endtask

  // kind: 0 random, 1 all hits, 2 pauses pressed (misses), 3 directed sequence.
  task automatic run_game(input int n, input int kind);
    int d_esp[5]  = '{3, 5, 5, 0, 0};
    int d_prs[5]  = '{1, 1, 0, 0, 1};
    int d_k[5]    = '{2, 1, 0, 0, 0};
    int d_code[5] = '{3, 4, 0, 0, 7};
    int d_dbl[5]  = '{0, 1, 0, 0, 0};
    int g0, m, esp, code, k;
    bit ok, press;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: pm_list[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
        1: pm_list[i] = int'($urandom_range(1, 15));
        2: pm_list[i] = 0;
        default: pm_list[i] = d_esp[i];
      endcase
    end
    pm_base = pm_cnt;
    pm_n = n;
    m_pont = 0; m_ac = 0; m_er = 0; m_seq = 0;
    g0 = grades;
    ifc.iniciar = 1'b1;
    @(negedge clk);
    ifc.iniciar = 1'b0;
    chk("start_pontuacao", int'(ifc.pontuacao), 0);
    chk("start_acertos", int'(ifc.acertos), 0);
    chk("start_erros", int'(ifc.erros), 0);
    chk("start_sequencia", int'(ifc.sequencia), 0);
    chk("start_resultado_acerto", int'(ifc.resultado_acerto), 0);
    chk("start_trocar", int'(ifc.trocar_comando), 1);
    for (int i = 0; i < n; i++) begin
      esp = pm_list[i];
      case (kind)
        0: begin
          m = int'($urandom_range(0, 3));
          press = (m != 0);
          code = (m == 2) ? (esp + int'($urandom_range(1, 15))) % 16 : esp;
          k = (m == 3) ? J - 1 : int'($urandom_range(0, J - 1));
          do_cmd(esp, press, k, code, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
        1: do_cmd(esp, 1'b1, 0, esp, 1'b0, 1'b0, 1'b0);
        2: do_cmd(esp, 1'b1, 0, int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        default: do_cmd(esp, d_prs[i] != 0, d_k[i], d_code[i], 1'b0, d_dbl[i] != 0, 1'b0);
      endcase
    end
    wait_trocar(ok);
    repeat (ESP + 2) @(negedge clk);
    chk("fim_jogando", int'(ifc.jogando), 0);
    chk("grade_count", grades - g0, n);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) begin
      ifc.jogada_valida = 1'b1;
      ifc.jogada = 4'($urandom_range(0, 15));
      @(negedge clk);
      ifc.jogada_valida = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("fim_hold_pontuacao", int'(ifc.pontuacao), m_pont);
    chk("fim_hold_acertos", int'(ifc.acertos), m_ac);
    chk("fim_hold_erros", int'(ifc.erros), m_er);
    chk("fim_hold_jogando", int'(ifc.jogando), 0);
  endtask

  task automatic reset_test();
    bit ok;
    for (int i = 0; i < 4; i++) pm_list[i] = 6;
    pm_base = pm_cnt;
    pm_n = 4;
    m_pont = 0; m_ac = 0; m_er = 0; m_seq = 0;
    ifc.iniciar = 1'b1;
    @(negedge clk);
    ifc.iniciar = 1'b0;
    do_cmd(6, 1'b1, 0, 6, 1'b0, 1'b0, 1'b0);
    wait_trocar(ok);
    repeat (1 + ESP + 3) @(negedge clk);
    ifc.jogada_valida = 1'b1;
    ifc.jogada = 4'd6;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.jogada_valida = 1'b0;
    chk("rst_trocar", int'(ifc.trocar_comando), 0);
    chk("rst_pontuacao", int'(ifc.pontuacao), 0);
    chk("rst_acertos", int'(ifc.acertos), 0);
    chk("rst_erros", int'(ifc.erros), 0);
    chk("rst_sequencia", int'(ifc.sequencia), 0);
    chk("rst_resultado_valido", int'(ifc.resultado_valido), 0);
    chk("rst_resultado_acerto", int'(ifc.resultado_acerto), 0);
    chk("rst_jogando", int'(ifc.jogando), 0);
    repeat (J + 4) @(negedge clk);
    chk("rst_idle_jogando", int'(ifc.jogando), 0);
    chk("rst_idle_trocar", int'(ifc.trocar_comando), 0);
    chk("rst_scoreboard_drained", sb.size(), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test expected finish before 90000 cycles");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    ifc.iniciar = 1'b0;
    ifc.jogada_valida = 1'b0;
    ifc.jogada = '0;
    repeat (3) @(negedge clk);
    chk("reset_trocar", int'(ifc.trocar_comando), 0);
    chk("reset_pontuacao", int'(ifc.pontuacao), 0);
    chk("reset_acertos", int'(ifc.acertos), 0);
    chk("reset_erros", int'(ifc.erros), 0);
    chk("reset_sequencia", int'(ifc.sequencia), 0);
    chk("reset_resultado_valido", int'(ifc.resultado_valido), 0);
    chk("reset_jogando", int'(ifc.jogando), 0);
    rst = 1'b0;
    @(negedge clk);

    run_game(5, 3);
    run_game(5, 1);
    reset_test();
    run_game(150, 0);
    run_game(150, 0);
    run_game(12, 1);
`ifdef COMBO_BONUS_EN
    chk("combo_12_hits", int'(ifc.pontuacao), 240);
`else
    chk("flat_12_hits", int'(ifc.pontuacao), 120);
`endif
    run_game(270, 2);
    chk("erros_saturated", int'(ifc.erros), 255);
    run_game(6560, 1);
    chk("pontuacao_saturated", int'(ifc.pontuacao), 65535);
    chk("acertos_saturated", int'(ifc.acertos), 255);
    chk("sequencia_saturated", int'(ifc.sequencia), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
